// File: rtl/ir_sensor_filter.sv
// IR sensor array front-end: 2-flop synchroniser, tick-sampled consecutive-sample
// glitch filter per channel, and a change interrupt with a sticky mask cleared by ACK.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no unacknowledged change, PENDING=0
// WAIT_ACK | change reported, CHANGE_MASK accumulating, PENDING=1
module ir_sensor_filter #(
  parameter int DIV      = 500,
  parameter int FILT_LEN = 4,
  parameter int WIDTH    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [WIDTH-1:0] IR_RAW,
  input  logic             ACK,
  output logic [WIDTH-1:0] SENSE_OUT,
  output logic [WIDTH-1:0] CHANGE_MASK,
  output logic             PENDING,
  output logic             CHANGE_INT
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [4:0]  FILT     = 5'(FILT_LEN);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sync1, sync2;
  logic [15:0]      div_cnt;
  logic             tick;
  logic [3:0]       cnt     [WIDTH];
  logic [3:0]       cnt_nxt [WIDTH];
  logic [WIDTH-1:0] sense_nxt;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] mask_nxt;
  logic             fire;
  logic             fire_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IR_RAW;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                  div_cnt <= '0;
    else if (!EN)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 16'd1;
  end

  assign tick = EN && (div_cnt == DIV_LAST);

  // Any agreeing sample restarts a channel's count, so only FILT_LEN
  // consecutive disagreeing ticks can flip the stable bit.
  always_comb begin
    sense_nxt = SENSE_OUT;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!EN) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (sync2[i] == SENSE_OUT[i]) begin
          cnt_nxt[i] = '0;
        end else if ({1'b0, cnt[i]} + 5'd1 == FILT) begin
          sense_nxt[i] = sync2[i];
          cnt_nxt[i]   = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  assign delta = sense_nxt ^ SENSE_OUT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      SENSE_OUT <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      SENSE_OUT <= sense_nxt;
    end
  end

  // An ACK colliding with a new change restarts the mask rather than clearing it.
  always_comb begin
    state_nxt = state;
    mask_nxt  = CHANGE_MASK;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (|delta) begin
          mask_nxt  = delta;
          fire      = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ACK && (|delta)) begin
          mask_nxt = delta;
          fire     = 1'b1;
        end else if (ACK) begin
          mask_nxt  = '0;
          state_nxt = IDLE;
        end else if (|delta) begin
          mask_nxt = CHANGE_MASK | delta;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      CHANGE_MASK <= '0;
      fire_q      <= 1'b0;
      CHANGE_INT  <= 1'b0;
    end else begin
      state       <= state_nxt;
      CHANGE_MASK <= mask_nxt;
      fire_q      <= fire;
      CHANGE_INT  <= fire_q;
    end
  end

  assign PENDING = (state == WAIT_ACK);

endmodule

// File: doc/ir_sensor_filter.md
Name: ir_sensor_filter

Overview:
- Front-end conditioner for the 8-channel IR sensor array.
- Synchronises the raw asynchronous photodiode comparator outputs and removes glitches with a per-channel consecutive-sample filter.
- Presents a stable byte to the MCU input-port mux at port 0xA6, and drives a one-cycle change interrupt with a sticky change mask, cleared by an MCU acknowledge.
- Sits directly upstream of the MCU wrapper's IRSENSOR input and interrupt OR-tree; runs in the 50 MHz MCU clock domain.

Parameters:
- DIV, 500, sample-tick period in CLK cycles (10 us at 50 MHz); legal range 2..65535.
- FILT_LEN, 4, consecutive disagreeing samples required to flip a stable bit; legal range 1..15.
- WIDTH, 8, number of sensor channels.

Ports:
- CLK  in  1  50 MHz system clock (MCU clock).
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  filter enable; low freezes outputs and clears filter state.
- IR_RAW  in  WIDTH  raw asynchronous sensor comparator outputs.
- ACK  in  1  one-cycle acknowledge from the MCU port-read decode; clears pending state.
- SENSE_OUT  out  WIDTH  filtered stable sensor value, to the input-port mux.
- CHANGE_MASK  out  WIDTH  sticky mask of bits that changed since the last ACK.
- PENDING  out  1  a change has not yet been acknowledged.
- CHANGE_INT  out  1  one-cycle interrupt pulse.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Synchroniser flops, prescaler, per-bit counters, SENSE_OUT, CHANGE_MASK, PENDING and CHANGE_INT all go to 0.
  - Release is sampled on the next rising CLK edge.
- Synchroniser: two-flop synchroniser on every IR_RAW bit; sync[i] is the second-stage value.
- Prescaler:
  - Counter runs 0..DIV-1.
  - tick=1 for exactly one cycle when the counter equals DIV-1, then the counter wraps to 0.
  - EN=0: counter held at 0 and no ticks are generated.
- Per-bit filter (WIDTH independent 4-bit counters cnt[i]), evaluated only on tick:
  - sync[i]==SENSE_OUT[i]: cnt[i]<=0.
  - Otherwise, if cnt[i]+1==FILT_LEN: SENSE_OUT[i]<=sync[i] and cnt[i]<=0.
  - Otherwise: cnt[i]<=cnt[i]+1.
  - A single agreeing sample restarts the count, so glitches shorter than FILT_LEN ticks never reach SENSE_OUT.
  - FILT_LEN=1: the bit follows sync on every tick.
- EN=0:
  - All cnt[i] cleared.
  - SENSE_OUT, CHANGE_MASK and PENDING hold their values.
  - ACK is still honoured.
- Latency: an IR_RAW edge appears on SENSE_OUT after 2 cycles (synchroniser) plus up to DIV cycles (tick alignment) plus (FILT_LEN-1)*DIV cycles. SENSE_OUT registers update on the tick edge.
- Change detection: delta = bits of SENSE_OUT updated on the current tick (old XOR new).
- Interrupt state machine, states IDLE (PENDING=0) and WAIT_ACK (PENDING=1):
  - IDLE, delta≠0: CHANGE_MASK<=delta, PENDING<=1, CHANGE_INT=1 on the following cycle (registered; one cycle after SENSE_OUT updates), go to WAIT_ACK.
  - WAIT_ACK, delta≠0, no ACK: CHANGE_MASK<=CHANGE_MASK|delta; no new pulse; stay.
  - WAIT_ACK, ACK, delta=0: CHANGE_MASK<=0, PENDING<=0, go to IDLE.
  - WAIT_ACK, ACK and delta≠0 in the same cycle: CHANGE_MASK<=delta (old bits discarded), PENDING stays 1, a new CHANGE_INT pulse is issued next cycle.
  - IDLE, ACK: ignored.
- CHANGE_INT is never high for more than one consecutive cycle.
- A bit toggling back to its original value before ACK leaves its mask bit set.
- Reset mid-filter discards all partial counts; no interrupt is produced by reset itself.

Test Plan (DIV=4, FILT_LEN=3 unless stated):
- Reset then release with IR_RAW=8'h00 for 100 cycles -> SENSE_OUT=00, CHANGE_MASK=00, PENDING=0, CHANGE_INT never asserted.
- IR_RAW 00->8'h81 held -> SENSE_OUT=81 within 2+4+8=14 cycles; CHANGE_MASK=81; PENDING=1; exactly one CHANGE_INT pulse, one cycle after SENSE_OUT updates.
- IR_RAW bit0 pulsed high for 2 ticks (8 cycles) then low -> SENSE_OUT stays 00, no interrupt; a 3-tick pulse -> SENSE_OUT[0]=1 and an interrupt.
- With PENDING=1 and mask=01, bit3 changes -> mask=09, no second pulse; then ACK -> mask=00, PENDING=0 on the next cycle.
- ACK in the same cycle as a tick that flips bit5 -> mask=20, PENDING=1, second CHANGE_INT pulse the next cycle.
- EN=0 with IR_RAW changing to FF for 50 cycles -> SENSE_OUT unchanged, no ticks; EN=1 -> SENSE_OUT=FF after 3 ticks. Also assert RESET low mid-count -> all outputs 0 immediately (asynchronous).
